if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, selects the next PC from the ID-stage branch unit's `pc_src`/`if_flush` decision, drives the instruction-memory address, and loads the IF/ID pipeline register. It sits directly upstream of the ID stage, where the branch unit resolves jumps and branches one cycle after fetch. Branch and jump targets are computed here from operands forwarded back from ID.

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 72 +++++++
 tb/tb_if_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, operand, instruction-memory and IF/ID signals.
// The master side is the fetch stage; the slave side is the surrounding pipeline.
interface if_stage_if;
    logic [1:0]  pc_src;
    logic        if_flush;
    logic        stall;
    logic [31:0] id_pc4;
    logic [31:0] id_simm;
    logic [25:0] id_target;
    logic [31:0] id_rs;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        addr_err;
    logic [15:0] flush_count;

    modport master (
        input  pc_src, if_flush, stall, id_pc4, id_simm, id_target, id_rs, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, addr_err, flush_count
    );

    modport slave (
        output pc_src, if_flush, stall, id_pc4, id_simm, id_target, id_rs, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, addr_err, flush_count
    );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: program counter, next-PC selection from the ID
// branch unit, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        jr_misaligned;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        addr_err;
    logic [15:0] flush_count;

    assign pc_plus4      = pc + 32'd4;
    assign jr_misaligned = (bus.pc_src == 2'b11) && (bus.id_rs[1:0] != 2'b00);

    // Branch offset is the word offset scaled to bytes; all sums wrap at 2^32.
    always_comb begin
        next_pc = pc_plus4;
        case (bus.pc_src)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = {bus.id_pc4[31:28], bus.id_target, 2'b00};
            2'b10: next_pc = bus.id_pc4 + {bus.id_simm[29:0], 2'b00};
            2'b11: next_pc = {bus.id_rs[31:2], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // Stall freezes everything except the error pulse, which always falls back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            addr_err    <= 1'b0;
            flush_count <= 16'd0;
        end else if (bus.stall) begin
            addr_err <= 1'b0;
        end else begin
            pc       <= next_pc;
            addr_err <= jr_misaligned;
            if (bus.if_flush) begin
                if_id_instr <= 32'd0;
                if_id_pc4   <= 32'd0;
                if_id_valid <= 1'b0;
                if (flush_count != 16'hFFFF) begin
                    flush_count <= flush_count + 16'd1;
                end
            end else begin
                if_id_instr <= bus.imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = if_id_instr;
    assign bus.if_id_pc4   = if_id_pc4;
    assign bus.if_id_valid = if_id_valid;
    assign bus.addr_err    = addr_err;
    assign bus.flush_count = flush_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: each step queues its hand-computed post-edge state,
// and an independent monitor pops and compares it one delta after the clock edge.
module tb_if_stage;

    logic clk;
    logic rst_n;
    if_stage_if bus ();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory: every word is distinct and derived from its address.
    assign bus.imem_rdata = 32'hA500_0000 ^ bus.imem_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        ae;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input string field,
                                input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
        end
    endtask

    // Monitor: compares the queued expectation against the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e.name, "pc",    bus.imem_addr,          e.pc);
                check_output(e.name, "instr", bus.if_id_instr,        e.instr);
                check_output(e.name, "pc4",   bus.if_id_pc4,          e.pc4);
                check_output(e.name, "valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
                check_output(e.name, "aerr",  {31'd0, bus.addr_err},    {31'd0, e.ae});
                check_output(e.name, "fcnt",  {16'd0, bus.flush_count}, {16'd0, e.fc});
            end
        end
    end

    task automatic drive(input logic rst, input logic stl, input logic flush,
                         input logic [1:0] src, input logic [31:0] pc4_in,
                         input logic [31:0] simm, input logic [25:0] tgt,
                         input logic [31:0] rs);
        rst_n         = rst;
        bus.stall     = stl;
        bus.if_flush  = flush;
        bus.pc_src    = src;
        bus.id_pc4    = pc4_in;
        bus.id_simm   = simm;
        bus.id_target = tgt;
        bus.id_rs     = rs;
    endtask

    task automatic apply_stimulus(input string name,
                                  input logic rst, input logic stl, input logic flush,
                                  input logic [1:0] src, input logic [31:0] pc4_in,
                                  input logic [31:0] simm, input logic [25:0] tgt,
                                  input logic [31:0] rs,
                                  input logic [31:0] e_pc, input logic [31:0] e_instr,
                                  input logic [31:0] e_pc4, input logic e_valid,
                                  input logic e_ae, input logic [15:0] e_fc);
        exp_t e;
        @(negedge clk);
        drive(rst, stl, flush, src, pc4_in, simm, tgt, rs);
        e.name = name; e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4;
        e.valid = e_valid; e.ae = e_ae; e.fc = e_fc;
        exp_q.push_back(e);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 26'd0, 32'd0);

        //             name        rst stl fl src    id_pc4        id_simm       tgt          id_rs          pc            instr         pc4           v    ae   fc
        apply_stimulus("reset0",   0, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0000, 32'h0,        32'h0,        0, 0, 16'd0);
        apply_stimulus("reset1",   0, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0000, 32'h0,        32'h0,        0, 0, 16'd0);
        apply_stimulus("seq1",     1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0004, 32'hA500_0000, 32'h4,       1, 0, 16'd0);
        apply_stimulus("seq2",     1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0008, 32'hA500_0004, 32'h8,       1, 0, 16'd0);
        apply_stimulus("seq3",     1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_000C, 32'hA500_0008, 32'hC,       1, 0, 16'd0);
        apply_stimulus("branch",   1, 0, 1, 2'b10, 32'h14,       32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_000C, 32'h0,        32'h0,        0, 0, 16'd1);
        apply_stimulus("postbr",   1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0010, 32'hA500_000C, 32'h10,      1, 0, 16'd1);
        apply_stimulus("jump",     1, 0, 1, 2'b01, 32'h4000_0010, 32'h0,       26'h0000040, 32'h0,         32'h4000_0100, 32'h0,        32'h0,        0, 0, 16'd2);
        apply_stimulus("postj",    1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h4000_0104, 32'hE500_0100, 32'h4000_0104, 1, 0, 16'd2);
        apply_stimulus("jrmis",    1, 0, 1, 2'b11, 32'h0,        32'h0,        26'h0,       32'h0000_1003, 32'h0000_1000, 32'h0,        32'h0,        0, 1, 16'd3);
        apply_stimulus("postjr",   1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_1004, 32'hA500_1000, 32'h1004,    1, 0, 16'd3);
        apply_stimulus("nfredir",  1, 0, 0, 2'b10, 32'h2000,     32'h4,        26'h0,       32'h0,         32'h0000_2010, 32'hA500_1004, 32'h1008,    1, 0, 16'd3);
        apply_stimulus("stall1",   1, 1, 1, 2'b10, 32'h14,       32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_2010, 32'hA500_1004, 32'h1008,    1, 0, 16'd3);
        apply_stimulus("stall2",   1, 1, 1, 2'b10, 32'h14,       32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_2010, 32'hA500_1004, 32'h1008,    1, 0, 16'd3);
        apply_stimulus("release",  1, 0, 1, 2'b10, 32'h14,       32'hFFFF_FFFE, 26'h0,      32'h0,         32'h0000_000C, 32'h0,        32'h0,        0, 0, 16'd4);
        apply_stimulus("postrel",  1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0010, 32'hA500_000C, 32'h10,      1, 0, 16'd4);
        apply_stimulus("jrnoflsh", 1, 0, 0, 2'b11, 32'h0,        32'h0,        26'h0,       32'h0000_2002, 32'h0000_2000, 32'hA500_0010, 32'h14,      1, 1, 16'd4);
        apply_stimulus("stallae",  1, 1, 1, 2'b11, 32'h0,        32'h0,        26'h0,       32'h0000_3001, 32'h0000_2000, 32'hA500_0010, 32'h14,      1, 0, 16'd4);
        apply_stimulus("jrtop",    1, 0, 1, 2'b11, 32'h0,        32'h0,        26'h0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h0,        0, 0, 16'd5);
        apply_stimulus("wrap",     1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0000, 32'h5AFF_FFFC, 32'h0,       1, 0, 16'd5);
        apply_stimulus("postwrap", 1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0004, 32'hA500_0000, 32'h4,       1, 0, 16'd5);
        apply_stimulus("midreset", 0, 1, 1, 2'b01, 32'h4000_0010, 32'h0,       26'h0000040, 32'h0,         32'h0000_0000, 32'h0,        32'h0,        0, 0, 16'd0);
        apply_stimulus("restart",  1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0004, 32'hA500_0000, 32'h4,       1, 0, 16'd0);

        // 65536 unchecked flushes, then one checked flush: 65537 in total.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 26'd0, 32'd0);
        repeat (65536) @(posedge clk);
        apply_stimulus("satflush", 1, 0, 1, 2'b11, 32'h0,        32'h0,        26'h0,       32'h0000_0100, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 16'hFFFF);
        apply_stimulus("postsat",  1, 0, 0, 2'b00, 32'h0,        32'h0,        26'h0,       32'h0,         32'h0000_0104, 32'hA500_0100, 32'h104,     1, 0, 16'hFFFF);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() > 0) begin
                errors++;
                $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
